bpc_decode: RTL

//  Receive-side BPC time-code decoder; counterpart of bpc_gen. Samples a demodulated BPC

---
 rtl/bpc_decode.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bpc_decode.sv
// BPC time-code receiver: classifies per-second pulse widths, locks to the sync marker
// and publishes decoded time/date fields. Define BPC_PARITY_CHECK_EN to enforce parity.
module bpc_decode #(
    parameter int UNIT     = 10,
    parameter int TOL      = 3,
    parameter int SYNC_GAP = 150,
    parameter int MAX_HIGH = 50,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       bpc_in,
    output logic       frame_valid,
    output logic       sym_err,
    output logic       parity_err,
    output logic       locked,
    output logic [3:0] hour,
    output logic [5:0] minute,
    output logic [2:0] week,
    output logic       pm,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year
);
    typedef enum logic {HUNT, RECV} state_t;

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] GAP_LAST = CW'(SYNC_GAP - 1);
    localparam logic [CW-1:0] HIGH_LIM = CW'(MAX_HIGH);
    localparam logic [4:0]    LAST_IDX = 5'd19;

    logic [1:0]    sync_q;
    logic          lvl_prev_q;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [37:0]   frame_q, frame_d;
    logic          fv_q, fv_d, se_q, se_d, pe_q, pe_d, locked_q, locked_d;
    logic [3:0]    hour_q, hour_d, month_q, month_d;
    logic [5:0]    minute_q, minute_d;
    logic [2:0]    week_q, week_d;
    logic          pm_q, pm_d;
    logic [4:0]    day_q, day_d;
    logic [6:0]    year_q, year_d;

    logic lvl, rise, fall, marker, too_long, sym_ok, par_ok;
    logic [1:0] sym;
    logic unused_bits;

    assign lvl  = sync_q[1];
    assign rise = lvl & ~lvl_prev_q;
    assign fall = ~lvl & lvl_prev_q;
    // Edge qualifiers keep stale counts from a previous level out of these one-shot events.
    assign marker   = ~lvl & ~fall & tick & (lo_cnt_q == GAP_LAST);
    assign too_long = lvl & ~rise & tick & (hi_cnt_q == HIGH_LIM);
    assign unused_bits = ^frame_q[37:36];

    always_comb begin
        hi_cnt_d = rise ? '0 : hi_cnt_q;
        if (lvl && tick && hi_cnt_d != CNT_MAX) hi_cnt_d = hi_cnt_d + 1'b1;
        lo_cnt_d = fall ? '0 : lo_cnt_q;
        if (!lvl && tick && lo_cnt_d != CNT_MAX) lo_cnt_d = lo_cnt_d + 1'b1;
    end

    always_comb begin
        sym_ok = 1'b0;
        sym    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (int'(hi_cnt_q) >= (k + 1) * UNIT - TOL && int'(hi_cnt_q) <= (k + 1) * UNIT + TOL) begin
                sym_ok = 1'b1;
                sym    = 2'(k);
            end
        end
    end

`ifdef BPC_PARITY_CHECK_EN
    assign par_ok = (frame_q[18] == ^frame_q[33:20]) && (frame_q[0] == ^frame_q[17:2]);
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        pe_d     = 1'b0;
        locked_d = locked_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        week_d   = week_q;
        pm_d     = pm_q;
        day_d    = day_q;
        month_d  = month_q;
        year_d   = year_q;
        case (state_q)
            HUNT: begin
                if (marker) begin
                    state_d = RECV;
                    idx_d   = '0;
                end
            end
            default: begin
                // Width faults only count while receiving; hunting discards everything.
                if (too_long) begin
                    se_d    = 1'b1;
                    state_d = HUNT;
                end else if (fall) begin
                    if (!sym_ok || idx_q == LAST_IDX) begin
                        se_d    = 1'b1;
                        state_d = HUNT;
                    end else begin
                        frame_d = {frame_q[35:0], sym};
                        idx_d   = idx_q + 5'd1;
                    end
                end else if (marker) begin
                    idx_d = '0;
                    if (idx_q != LAST_IDX) begin
                        se_d = 1'b1;
                    end else if (!par_ok) begin
                        pe_d = 1'b1;
                    end else begin
                        fv_d     = 1'b1;
                        hour_d   = frame_q[33:30];
                        minute_d = frame_q[29:24];
                        week_d   = frame_q[22:20];
                        pm_d     = frame_q[19];
                        day_d    = frame_q[16:12];
                        month_d  = frame_q[11:8];
                        year_d   = {frame_q[1], frame_q[7:2]};
                    end
                end
            end
        endcase
        if (fv_d) locked_d = 1'b1;
        if (se_d || pe_d) locked_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
            hi_cnt_q   <= '0;
            lo_cnt_q   <= '0;
            state_q    <= HUNT;
            idx_q      <= '0;
            frame_q    <= '0;
            fv_q       <= 1'b0;
            se_q       <= 1'b0;
            pe_q       <= 1'b0;
            locked_q   <= 1'b0;
            hour_q     <= '0;
            minute_q   <= '0;
            week_q     <= '0;
            pm_q       <= 1'b0;
            day_q      <= '0;
            month_q    <= '0;
            year_q     <= '0;
        end else begin
            sync_q     <= {sync_q[0], bpc_in};
            lvl_prev_q <= lvl;
            hi_cnt_q   <= hi_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            fv_q       <= fv_d;
            se_q       <= se_d;
            pe_q       <= pe_d;
            locked_q   <= locked_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            week_q     <= week_d;
            pm_q       <= pm_d;
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
        end
    end

    assign frame_valid = fv_q;
    assign sym_err     = se_q;
    assign parity_err  = pe_q;
    assign locked      = locked_q;
    assign hour        = hour_q;
    assign minute      = minute_q;
    assign week        = week_q;
    assign pm          = pm_q;
    assign day         = day_q;
    assign month       = month_q;
    assign year        = year_q;
endmodule
